wb_arbiter_n: RTL
=================

// Module: wb_arbiter_n
// PURPOSE
//  N-way Wishbone B4 pipelined bus arbiter: NUM_MASTERS masters share one slave port.
//  Selectable round-robin or fixed-priority grant. Grant is held for a master's whole
//  cyc assertion, then one dead cycle. Sits between CPU/cache/DMA masters and the memory
//  or peripheral interconnect; the generalised replacement for two-port arbitration.
// PARAMETERS
//  NUM_MASTERS  4   number of master ports (2..16)
//  ADR_W        32  address width
//  DAT_W        32  data width (multiple of 8)
//  SEL_W        DAT_W/8  byte-select width (derived, do not override)
//  RR_MODE      1   1 = round-robin, 0 = fixed priority (highest index wins)
// PORTS
//  clk_i     in   1                   clock, all logic on rising edge
//  rst_ni    in   1                   reset, asynchronous assert, active low
//  m_cyc_i   in   NUM_MASTERS         per-master cyc
//  m_stb_i   in   NUM_MASTERS         per-master stb
//  m_we_i    in   NUM_MASTERS         per-master we
//  m_adr_i   in   NUM_MASTERS*ADR_W   per-master address, master k at [k*ADR_W +: ADR_W]
//  m_sel_i   in   NUM_MASTERS*SEL_W   per-master byte selects, packed as m_adr_i
//  m_dat_i   in   NUM_MASTERS*DAT_W   per-master write data, packed as m_adr_i
//  m_dat_o   out  DAT_W               read data, broadcast to all masters
//  m_ack_o   out  NUM_MASTERS         per-master ack
//  m_err_o   out  NUM_MASTERS         per-master err
//  m_stall_o out  NUM_MASTERS         per-master stall
//  s_cyc_o, s_stb_o, s_we_o  out 1    slave-side controls
//  s_adr_o   out  ADR_W               slave address
//  s_sel_o   out  SEL_W               slave byte selects
//  s_dat_o   out  DAT_W               slave write data
//  s_dat_i   in   DAT_W               slave read data
//  s_ack_i, s_err_i, s_stall_i  in 1  slave responses
//  gnt_o     out  NUM_MASTERS         one-hot current grant (registered), 0 when none
// BEHAVIOUR
//  - Reset (rst_ni low, async): state=IDLE, gnt_o=0, rr pointer=NUM_MASTERS-1
//    (master 0 wins the first RR arbitration). All s_* outputs 0, m_ack_o/m_err_o 0,
//    m_stall_o all 1. A reset mid-transfer drops s_cyc_o immediately. No response is
//    owed to the interrupted master.
//  - FSM states:
//    IDLE: no grant. If any m_cyc_i is set, compute the winner and register gnt_o -> GRANT.
//    GRANT: s_* mirror master g combinationally. When m_cyc_i[g] is 0 -> END.
//    END: one dead cycle with s_cyc_o=0 -> IDLE.
//  - Arbitration latency: a request seen in IDLE gets its first unstalled cycle at the
//    next edge. Minimum gap between two grants is 2 idle cycles (END + IDLE).
//  - Winner: RR_MODE=1 scans upward from pointer+1, modulo NUM_MASTERS, for the first
//    set cyc. The pointer updates to the winner on IDLE->GRANT. RR_MODE=0 picks the
//    highest set index. Simultaneous requests are resolved only by this rule.
//  - In GRANT with master g:
//    - s_cyc/stb/we/adr/sel/dat = master g fields.
//    - m_stall_o[g] = s_stall_i; m_ack_o[g] = s_ack_i; m_err_o[g] = s_err_i.
//  - Non-granted masters (and all masters outside GRANT): stall=1, ack=0, err=0.
//  - Outside GRANT: s_* = 0.
//  - m_dat_o = s_dat_i always, unregistered. Masters qualify it with their own ack.
//  - Grant is never pre-empted. A master holding cyc keeps the bus indefinitely.
//    Masters must hold cyc until all outstanding acks/errs return.
//  - Acks arriving in END/IDLE (a protocol violation) are dropped, not routed.
//  - Master cyc that drops in IDLE before arbitration is simply not granted.
//    A cyc raised during END waits for IDLE.
// TESTING
//  1. Reset release, master 1 raises cyc+stb reading 0x100 -> gnt_o=0010 next edge;
//     s_adr_o=0x100. s_dat_i=0xDEADBEEF with ack -> m_ack_o=0010, m_dat_o=0xDEADBEEF.
//  2. RR, all 4 masters hold cyc for 3-cycle bursts -> grant order 0,1,2,3,0 with
//     2-cycle gaps. RR_MODE=0, same stimulus -> master 3 is granted repeatedly.
//  3. Master 2 granted, master 0 raises cyc -> m_stall_o[0]=1 and m_ack_o[0]=0 for the
//     whole of master 2's cycle. Master 0 is granted 2 cycles after m_cyc_i[2] falls.
//  4. Pipelined writes: master 0 issues 4 stb beats with s_stall_i high on beat 2 ->
//     m_stall_o[0] follows s_stall_i. s_dat_o/s_sel_o match each beat. 4 acks routed.
//  5. s_err_i on a granted read -> m_err_o[g]=1, m_ack_o[g]=0, all other bits 0.
//  6. Assert rst_ni low mid-burst at a non-edge time -> s_cyc_o=0 and gnt_o=0
//     immediately. After release, master 0 is the first RR winner.

Source files
------------

// File: rtl/wb_arbiter_n_if.sv
// Bundle of per-master Wishbone request/response lanes plus the shared slave port.
// The arbiter takes the slave modport; masters and the slave model share the master modport.
interface wb_arbiter_n_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ADR_W       = 32,
  parameter int DAT_W       = 32
);
  localparam int SEL_W = DAT_W / 8;

  logic [NUM_MASTERS-1:0]       m_cyc_i;
  logic [NUM_MASTERS-1:0]       m_stb_i;
  logic [NUM_MASTERS-1:0]       m_we_i;
  logic [NUM_MASTERS*ADR_W-1:0] m_adr_i;
  logic [NUM_MASTERS*SEL_W-1:0] m_sel_i;
  logic [NUM_MASTERS*DAT_W-1:0] m_dat_i;
  logic [DAT_W-1:0]             m_dat_o;
  logic [NUM_MASTERS-1:0]       m_ack_o;
  logic [NUM_MASTERS-1:0]       m_err_o;
  logic [NUM_MASTERS-1:0]       m_stall_o;

  logic                         s_cyc_o;
  logic                         s_stb_o;
  logic                         s_we_o;
  logic [ADR_W-1:0]             s_adr_o;
  logic [SEL_W-1:0]             s_sel_o;
  logic [DAT_W-1:0]             s_dat_o;
  logic [DAT_W-1:0]             s_dat_i;
  logic                         s_ack_i;
  logic                         s_err_i;
  logic                         s_stall_i;

  logic [NUM_MASTERS-1:0]       gnt_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    input  s_dat_i, s_ack_i, s_err_i, s_stall_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    output gnt_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    output s_dat_i, s_ack_i, s_err_i, s_stall_i,
    input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o,
    input  gnt_o
  );
endinterface

// File: rtl/wb_arbiter_n.sv
// N-way Wishbone B4 pipelined arbiter: round-robin or fixed-priority grant, held for
// the winner's whole cyc assertion, followed by one dead cycle before re-arbitration.
module wb_arbiter_n #(
  parameter int NUM_MASTERS = 4,
  parameter int ADR_W       = 32,
  parameter int DAT_W       = 32,
  parameter int RR_MODE     = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  wb_arbiter_n_if.slave bus
);
  localparam int SEL_W = DAT_W / 8;
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_END   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_found;
  logic                   granted;
  logic [NUM_MASTERS-1:0] lane_sel;
  int                     scan_idx;

  // Round-robin starts one past the last winner; fixed priority lets the highest index win.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = 0;
    if (RR_MODE != 0) begin
      for (int i = 1; i <= NUM_MASTERS; i++) begin
        scan_idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
        if (!win_found && bus.m_cyc_i[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(scan_idx);
        end
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (bus.m_cyc_i[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d         = ST_GRANT;
          gidx_d          = win_idx;
          gnt_d           = '0;
          gnt_d[win_idx]  = 1'b1;
          if (RR_MODE != 0) begin
            rr_ptr_d = win_idx;
          end
        end
      end
      ST_GRANT: begin
        if (!bus.m_cyc_i[gidx_q]) begin
          state_d = ST_END;
          gnt_d   = '0;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign granted = (state_q == ST_GRANT);

  // Slave side mirrors the granted master combinationally; zero whenever no grant is live.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_sel_o = '0;
    bus.s_dat_o = '0;
    if (granted) begin
      bus.s_cyc_o = bus.m_cyc_i[gidx_q];
      bus.s_stb_o = bus.m_stb_i[gidx_q];
      bus.s_we_o  = bus.m_we_i[gidx_q];
      bus.s_adr_o = bus.m_adr_i[int'(gidx_q)*ADR_W +: ADR_W];
      bus.s_sel_o = bus.m_sel_i[int'(gidx_q)*SEL_W +: SEL_W];
      bus.s_dat_o = bus.m_dat_i[int'(gidx_q)*DAT_W +: DAT_W];
    end
  end

  // Responses outside GRANT are protocol violations and are swallowed here.
  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_lane
    assign lane_sel[gi]      = granted && (gidx_q == IDX_W'(gi));
    assign bus.m_ack_o[gi]   = lane_sel[gi] & bus.s_ack_i;
    assign bus.m_err_o[gi]   = lane_sel[gi] & bus.s_err_i;
    assign bus.m_stall_o[gi] = lane_sel[gi] ? bus.s_stall_i : 1'b1;
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.gnt_o   = gnt_q;
endmodule
